mem_access_master: RTL and testbench

- Initiator side of the Wr_En/Rd_En/Address/Data_in ↔ Data_out/Valid_out single-port memory interface.
- Accepts host read/write requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues exactly one memory operation at a time and never asserts write and read strobes together.
- Captures read data on Valid_out and returns an in-order response (read data or write ack, with timeout error) to the host.

---
 rtl/mem_access_master.sv | 156 +++++++++++++++
 tb/tb_mem_access_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_master.sv
// Initiator for a single-port Wr_En/Rd_En memory: queues host requests in a small FIFO,
// runs one memory operation at a time and returns in-order responses with read timeout.
module mem_access_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic                  CLK,
  input  logic                  Rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  mem_Wr_En,
  output logic                  mem_Rd_En,
  output logic [ADDR_WIDTH-1:0] mem_Address,
  output logic [DATA_WIDTH-1:0] mem_Data_in,
  input  logic [DATA_WIDTH-1:0] mem_Data_out,
  input  logic                  mem_Valid_out,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   PTR_INC     = (PTR_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_INC     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WR, RD, WAIT_RD} state_t;

  state_t                state;
  logic                  fifo_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic [CNT_W-1:0]      timeout_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  // The extra pointer bit separates full (wrap bits differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty && (!rsp_valid || rsp_ready);
  assign busy       = !fifo_empty || (state != IDLE) || rsp_valid;

  assign head_write = fifo_write[rd_ptr[PTR_W-1:0]];
  assign head_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign head_wdata = fifo_wdata[rd_ptr[PTR_W-1:0]];
  assign cnt_next   = timeout_cnt + CNT_INC;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_write[wr_ptr[PTR_W-1:0]] <= req_write;
      fifo_addr[wr_ptr[PTR_W-1:0]]  <= req_addr;
      fifo_wdata[wr_ptr[PTR_W-1:0]] <= req_wdata;
    end
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_INC;
      if (pop)  rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  // A response load later in this block overrides the handshake clear on the same edge.
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      mem_Wr_En   <= 1'b0;
      mem_Rd_En   <= 1'b0;
      mem_Address <= '0;
      mem_Data_in <= '0;
      timeout_cnt <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_write <= 1'b0;
        rsp_rdata <= '0;
        rsp_error <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            mem_Address <= head_addr;
            mem_Data_in <= head_wdata;
            if (head_write) begin
              mem_Wr_En <= 1'b1;
              state     <= WR;
            end else begin
              mem_Rd_En <= 1'b1;
              state     <= RD;
            end
          end
        end
        WR: begin
          mem_Wr_En <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          rsp_error <= 1'b0;
          state     <= IDLE;
        end
        RD: begin
          mem_Rd_En   <= 1'b0;
          timeout_cnt <= '0;
          state       <= WAIT_RD;
        end
        WAIT_RD: begin
          if (mem_Valid_out) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= mem_Data_out;
            rsp_error <= 1'b0;
            state     <= IDLE;
          end else begin
            timeout_cnt <= cnt_next;
            if (cnt_next == CNT_TIMEOUT) begin
              rsp_valid <= 1'b1;
              rsp_write <= 1'b0;
              rsp_rdata <= '0;
              rsp_error <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Randomized scoreboard bench for mem_access_master with a 1-cycle memory model
// and a reference memory image that predicts every in-order response.
module tb_mem_access_master;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          Rst_n = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          mem_Wr_En, mem_Rd_En, mem_Valid_out, busy;
  logic [AW-1:0] mem_Address;
  logic [DW-1:0] mem_Data_in, mem_Data_out;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          e;
  } rsp_t;

  rsp_t          sbQ[$];
  logic [DW-1:0] refMem   [32];
  logic [DW-1:0] modelMem [32];
  bit            refInit = 1'b0;
  bit            preloaded = 1'b0;
  bit            noValid = 1'b0;
  bit            randReady = 1'b0;
  logic          randBit = 1'b1;
  logic          readyCmd = 1'b1;
  int            checks = 0;
  int            failures = 0;
  logic          prevHold = 1'b0;
  logic          prevW, prevE;
  logic [DW-1:0] prevData;

  always #5 CLK = ~CLK;

  assign rsp_ready = randReady ? randBit : readyCmd;

  mem_access_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_Wr_En(mem_Wr_En), .mem_Rd_En(mem_Rd_En), .mem_Address(mem_Address),
    .mem_Data_in(mem_Data_in), .mem_Data_out(mem_Data_out),
    .mem_Valid_out(mem_Valid_out), .busy(busy)
  );

  function automatic logic [DW-1:0] preload(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0001_0011;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory: reads return data one cycle after the strobe unless noValid starves it.
  always @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_Valid_out <= 1'b0;
      mem_Data_out  <= '0;
    end else begin
      if (!preloaded) begin
        for (int i = 0; i < 32; i++) modelMem[i] <= preload(i);
        preloaded <= 1'b1;
      end
      if (mem_Wr_En) modelMem[mem_Address] <= mem_Data_in;
      mem_Valid_out <= mem_Rd_En && !noValid;
      mem_Data_out  <= mem_Rd_En ? modelMem[mem_Address] : '0;
    end
  end

  always @(posedge CLK) begin
    #1;
    randBit = 1'($urandom_range(0, 1));
  end

  // Monitor and scoreboard: checks responses, then predicts newly accepted requests.
  always @(negedge CLK) begin : sbBlock
    rsp_t e;
    if (!refInit) begin
      for (int i = 0; i < 32; i++) refMem[i] = preload(i);
      refInit = 1'b1;
    end
    if (!Rst_n) begin
      sbQ.delete();
      prevHold = 1'b0;
    end else begin
      if (prevHold)
        checkOutput("rsp_hold", 64'({rsp_valid, rsp_write, rsp_error, rsp_rdata}),
                    64'({1'b1, prevW, prevE, prevData}));
      checkOutput("strobe_excl", 64'(mem_Wr_En && mem_Rd_En), 64'd0);
      if (rsp_valid && rsp_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp: actual=rsp_valid required=no response at %0t", $time);
        end else begin
          e = sbQ.pop_front();
          checkOutput("rsp", 64'({rsp_write, rsp_error, rsp_rdata}), 64'({e.w, e.e, e.d}));
        end
      end
      prevHold = rsp_valid && !rsp_ready;
      prevW    = rsp_write;
      prevE    = rsp_error;
      prevData = rsp_rdata;
      if (req_valid && req_ready) begin
        e.w = req_write;
        if (req_write) begin
          refMem[req_addr] = req_wdata;
          e.d = '0;
          e.e = 1'b0;
        end else if (noValid) begin
          e.d = '0;
          e.e = 1'b1;
        end else begin
          e.d = refMem[req_addr];
          e.e = 1'b0;
        end
        sbQ.push_back(e);
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   n = 0;
    logic accepted;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    forever begin
      @(negedge CLK);
      accepted = req_ready;
      @(posedge CLK);
      #1;
      if (accepted) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL req_accept: actual=not accepted required=accepted within 200 cycles");
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy || sbQ.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: actual=busy required=idle within 300 cycles");
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_outputs", 64'({rsp_valid, busy, mem_Wr_En, mem_Rd_En, rsp_write, rsp_error}), 64'd0);
    checkOutput("reset_mem_addr", 64'({mem_Address, mem_Data_in}), 64'd0);
    checkOutput("reset_rdata", 64'(rsp_rdata), 64'd0);
    Rst_n = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] write then read latency");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd5; req_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    checkOutput("wr_ready", 64'(req_ready), 64'd1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    @(negedge CLK);
    checkOutput("wr_e0_strobe", 64'(mem_Wr_En), 64'd0);
    @(negedge CLK);
    checkOutput("wr_e1_strobe", 64'({mem_Wr_En, mem_Rd_En}), 64'b10);
    checkOutput("wr_e1_addr", 64'({mem_Address, mem_Data_in}), 64'({5'd5, 32'hDEADBEEF}));
    @(negedge CLK);
    checkOutput("wr_e2", 64'({mem_Wr_En, rsp_valid, rsp_write, rsp_error}), 64'b0110);
    @(posedge CLK);
    #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    @(negedge CLK);
    checkOutput("rd_e0_strobe", 64'(mem_Rd_En), 64'd0);
    @(negedge CLK);
    checkOutput("rd_e1_strobe", 64'({mem_Wr_En, mem_Rd_En, mem_Address}), 64'({2'b01, 5'd5}));
    @(negedge CLK);
    checkOutput("rd_e2", 64'({mem_Rd_En, rsp_valid}), 64'd0);
    @(negedge CLK);
    checkOutput("rd_e3", 64'({rsp_valid, rsp_write, rsp_error, rsp_rdata}), 64'({3'b100, 32'hDEADBEEF}));
    waitIdle();

    $display("[TB] back-to-back random requests");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(6, 30)), $urandom());
    waitIdle();

    $display("[TB] response stall");
    readyCmd = 1'b0;
    applyStimulus(1'b0, 5'd5, '0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("stall_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    @(posedge CLK);
    #1;
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 5'(6 + i), $urandom());
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd10; req_wdata = 32'h0BAD_F00D;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkOutput("stall_full", 64'({req_ready, busy, mem_Wr_En, mem_Rd_En}), 64'b0100);
      checkOutput("stall_rdata_hold", 64'({rsp_valid, rsp_rdata}), 64'({1'b1, 32'hDEADBEEF}));
    end
    readyCmd = 1'b1;
    applyStimulus(1'b1, 5'd10, 32'h0BAD_F00D);
    waitIdle();

    $display("[TB] read timeout");
    noValid = 1'b1;
    applyStimulus(1'b0, 5'd31, '0);
    n = 0;
    while (!mem_Rd_En && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("to_rd_strobe", 64'(mem_Rd_En), 64'd1);
    @(negedge CLK);
    checkOutput("to_rd_fall", 64'({mem_Rd_En, rsp_valid}), 64'd0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge CLK);
      if (k < TO) checkOutput("to_wait", 64'(rsp_valid), 64'd0);
      else checkOutput("to_error", 64'({rsp_valid, rsp_error, rsp_write, rsp_rdata}), 64'({3'b110, 32'd0}));
    end
    waitIdle();
    noValid = 1'b0;
    applyStimulus(1'b1, 5'd31, 32'h1234_5678);
    applyStimulus(1'b0, 5'd31, '0);
    waitIdle();

    $display("[TB] reset during read wait");
    noValid = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 5'($urandom_range(0, 31)), '0);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("rst_strobes", 64'({mem_Wr_En, mem_Rd_En, rsp_valid, busy}), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    noValid = 1'b0;
    Rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checkOutput("rst_no_stale", 64'({rsp_valid, mem_Rd_En, mem_Wr_En, busy}), 64'd0);
    end
    @(posedge CLK);
    #1;

    $display("[TB] address boundaries");
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 5'd31, '0);
    applyStimulus(1'b1, 5'd31, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 5'd0, '0);
    applyStimulus(1'b0, 5'd31, '0);
    waitIdle();

    $display("[TB] random traffic with random rsp_ready");
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    waitIdle();
    randReady = 1'b0;
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
